bip_host_bridge: RTL and testbench

Host-side UART bridge between the BIP CPU and the UART RX/TX pair. It is the parametrised successor of the single-command start/send interface.
- Decodes command bytes from RX: start, CPU reset, resend last result. Any other byte is an unknown command.
- Latches the CPU result into a shadow register when the CPU finishes.
- Streams the result to TX as a variable-length little-endian frame with an optional header byte.
- Adds a run timeout, error/ack replies and an overrun flag.

---
 rtl/bip_host_bridge_if.sv | 29 ++
 rtl/bip_host_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_bip_host_bridge.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_host_bridge_if.sv
// rtl/bip_host_bridge_if.sv - UART/CPU signal bundle for the BIP host bridge
interface bip_host_bridge_if #(
  parameter int NB_BYTE = 8,
  parameter int NB_ACC  = 16,
  parameter int NB_CLK  = 8
);
  logic               rx_done_tick;
  logic [NB_BYTE-1:0] rx_data;
  logic               tx_done_tick;
  logic               tx_start;
  logic [NB_BYTE-1:0] tx_data;
  logic               cpu_done;
  logic [NB_ACC-1:0]  in_acc;
  logic [NB_CLK-1:0]  in_clk_count;
  logic               cpu_start;
  logic               cpu_reset;
  logic               busy;
  logic               overrun;

  modport master (
    input  rx_done_tick, rx_data, tx_done_tick, cpu_done, in_acc, in_clk_count,
    output tx_start, tx_data, cpu_start, cpu_reset, busy, overrun
  );

  modport slave (
    output rx_done_tick, rx_data, tx_done_tick, cpu_done, in_acc, in_clk_count,
    input  tx_start, tx_data, cpu_start, cpu_reset, busy, overrun
  );
endinterface

// File: rtl/bip_host_bridge.sv
// rtl/bip_host_bridge.sv - UART host bridge: command decode, CPU run control, result frame streaming
module bip_host_bridge #(
  parameter int NB_BYTE     = 8,
  parameter int NB_ACC      = 16,
  parameter int NB_CLK      = 8,
  parameter int HEADER_EN   = 1,
  parameter int RUN_TIMEOUT = 1024
) (
  input logic               clk,
  input logic               reset,
  bip_host_bridge_if.master bus
);
  localparam int ACC_BYTES = (NB_ACC + NB_BYTE - 1) / NB_BYTE;
  localparam int CLK_BYTES = (NB_CLK + NB_BYTE - 1) / NB_BYTE;
  localparam int PAY_BYTES = ACC_BYTES + CLK_BYTES;
  localparam int FRAME_LEN = HEADER_EN + PAY_BYTES;
  localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TMO_W     = $clog2(RUN_TIMEOUT + 2);

  localparam logic [NB_BYTE-1:0] CMD_START  = NB_BYTE'(8'h01);
  localparam logic [NB_BYTE-1:0] CMD_RESET  = NB_BYTE'(8'h02);
  localparam logic [NB_BYTE-1:0] CMD_RESEND = NB_BYTE'(8'h03);
  localparam logic [NB_BYTE-1:0] HDR_BYTE   = NB_BYTE'(8'hA5);
  localparam logic [NB_BYTE-1:0] ACK_BYTE   = NB_BYTE'(8'hAC);
  localparam logic [NB_BYTE-1:0] ERR_TMO    = NB_BYTE'(8'hE1);
  localparam logic [NB_BYTE-1:0] ERR_NORES  = NB_BYTE'(8'hE2);
  localparam logic [NB_BYTE-1:0] ERR_CMD    = NB_BYTE'(8'hEE);

  typedef enum logic [1:0] {IDLE, RUN, LOAD, WAIT_TX} state_t;

  state_t             state, state_n;
  logic               rx_prev, tx_prev;
  logic [NB_ACC-1:0]  acc_sh, acc_sh_n;
  logic [NB_CLK-1:0]  clk_sh, clk_sh_n;
  logic               result_valid, result_valid_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic               run_first, run_first_n;
  logic               single, single_n;
  logic [NB_BYTE-1:0] single_byte, single_byte_n;
  logic               tx_start_q, tx_start_n;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_n;
  logic               cpu_start_q, cpu_start_n;
  logic               cpu_reset_q, cpu_reset_n;
  logic               busy_q, busy_n;
  logic               overrun_q, overrun_n;

  logic               rx_rise, tx_rise;
  logic [PAY_BYTES*NB_BYTE-1:0] payload;
  logic [NB_BYTE-1:0] frame [FRAME_LEN];
  logic [NB_BYTE-1:0] frame_byte;
  logic               last_byte;

  assign rx_rise = bus.rx_done_tick & ~rx_prev;
  assign tx_rise = bus.tx_done_tick & ~tx_prev;

  // Frame is built from the shadow copy so a resend never sees live CPU values.
  always_comb begin
    payload = '0;
    payload[NB_ACC-1:0] = acc_sh;
    payload[ACC_BYTES*NB_BYTE +: NB_CLK] = clk_sh;
    for (int i = 0; i < FRAME_LEN; i++) frame[i] = '0;
    if (HEADER_EN != 0) frame[0] = HDR_BYTE;
    for (int i = 0; i < PAY_BYTES; i++) frame[HEADER_EN + i] = payload[i*NB_BYTE +: NB_BYTE];
  end

  assign frame_byte = single ? single_byte : frame[idx];
  assign last_byte  = single || (idx == IDX_W'(FRAME_LEN - 1));

  always_comb begin
    state_n        = state;
    acc_sh_n       = acc_sh;
    clk_sh_n       = clk_sh;
    result_valid_n = result_valid;
    idx_n          = idx;
    tmo_cnt_n      = tmo_cnt;
    run_first_n    = run_first;
    single_n       = single;
    single_byte_n  = single_byte;
    tx_start_n     = 1'b0;
    tx_data_n      = tx_data_q;
    cpu_start_n    = 1'b0;
    cpu_reset_n    = 1'b0;
    overrun_n      = overrun_q;

    if (rx_rise && state != IDLE) overrun_n = 1'b1;

    case (state)
      IDLE: begin
        if (rx_rise) begin
          overrun_n = 1'b0;
          idx_n     = '0;
          single_n  = 1'b1;
          state_n   = LOAD;
          case (bus.rx_data)
            CMD_START: begin
              cpu_start_n = 1'b1;
              tmo_cnt_n   = '0;
              run_first_n = 1'b1;
              state_n     = RUN;
            end
            CMD_RESET: begin
              cpu_reset_n    = 1'b1;
              result_valid_n = 1'b0;
              single_byte_n  = ACK_BYTE;
            end
            CMD_RESEND: begin
              if (result_valid) single_n = 1'b0;
              else              single_byte_n = ERR_NORES;
            end
            default: single_byte_n = ERR_CMD;
          endcase
        end
      end
      RUN: begin
        run_first_n = 1'b0;
        // The start cycle may still see the previous run's done level.
        if (!run_first && bus.cpu_done) begin
          acc_sh_n       = bus.in_acc;
          clk_sh_n       = bus.in_clk_count;
          result_valid_n = 1'b1;
          single_n       = 1'b0;
          idx_n          = '0;
          state_n        = LOAD;
        end else if (RUN_TIMEOUT > 0 && tmo_cnt == TMO_W'(RUN_TIMEOUT - 1)) begin
          single_n      = 1'b1;
          single_byte_n = ERR_TMO;
          idx_n         = '0;
          state_n       = LOAD;
        end else if (RUN_TIMEOUT > 0) begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end
      LOAD: begin
        tx_data_n  = frame_byte;
        tx_start_n = 1'b1;
        state_n    = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_rise) begin
          if (last_byte) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rx_prev      <= 1'b0;
      tx_prev      <= 1'b0;
      acc_sh       <= '0;
      clk_sh       <= '0;
      result_valid <= 1'b0;
      idx          <= '0;
      tmo_cnt      <= '0;
      run_first    <= 1'b0;
      single       <= 1'b0;
      single_byte  <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      cpu_start_q  <= 1'b0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state        <= state_n;
      rx_prev      <= bus.rx_done_tick;
      tx_prev      <= bus.tx_done_tick;
      acc_sh       <= acc_sh_n;
      clk_sh       <= clk_sh_n;
      result_valid <= result_valid_n;
      idx          <= idx_n;
      tmo_cnt      <= tmo_cnt_n;
      run_first    <= run_first_n;
      single       <= single_n;
      single_byte  <= single_byte_n;
      tx_start_q   <= tx_start_n;
      tx_data_q    <= tx_data_n;
      cpu_start_q  <= cpu_start_n;
      cpu_reset_q  <= cpu_reset_n;
      busy_q       <= busy_n;
      overrun_q    <= overrun_n;
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.cpu_start = cpu_start_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_bip_host_bridge.sv
// tb/tb_bip_host_bridge.sv - scoreboard bench for bip_host_bridge, two parameter sets
module tb_bip_host_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rx_tick [2];
  logic [7:0]  rx_byte [2];
  logic        tx_tick [2];
  logic        done    [2];
  logic [31:0] acc_v   [2];
  logic [31:0] clk_v   [2];
  logic        txs [2];
  logic [7:0]  txd [2];
  logic        cs  [2];
  logic        cr  [2];
  logic        bsy [2];
  logic        ovr [2];

  bip_host_bridge_if #(.NB_BYTE(8), .NB_ACC(16), .NB_CLK(8))  if0 ();
  bip_host_bridge_if #(.NB_BYTE(8), .NB_ACC(24), .NB_CLK(12)) if1 ();

  bip_host_bridge #(.NB_BYTE(8), .NB_ACC(16), .NB_CLK(8), .HEADER_EN(1), .RUN_TIMEOUT(50))
    u0 (.clk(clk), .reset(rst_n), .bus(if0.master));
  bip_host_bridge #(.NB_BYTE(8), .NB_ACC(24), .NB_CLK(12), .HEADER_EN(0), .RUN_TIMEOUT(0))
    u1 (.clk(clk), .reset(rst_n), .bus(if1.master));

  assign if0.rx_done_tick = rx_tick[0];
  assign if0.rx_data      = rx_byte[0];
  assign if0.tx_done_tick = tx_tick[0];
  assign if0.cpu_done     = done[0];
  assign if0.in_acc       = acc_v[0][15:0];
  assign if0.in_clk_count = clk_v[0][7:0];
  assign if1.rx_done_tick = rx_tick[1];
  assign if1.rx_data      = rx_byte[1];
  assign if1.tx_done_tick = tx_tick[1];
  assign if1.cpu_done     = done[1];
  assign if1.in_acc       = acc_v[1][23:0];
  assign if1.in_clk_count = clk_v[1][11:0];

  assign txs[0] = if0.tx_start;  assign txs[1] = if1.tx_start;
  assign txd[0] = if0.tx_data;   assign txd[1] = if1.tx_data;
  assign cs[0]  = if0.cpu_start; assign cs[1]  = if1.cpu_start;
  assign cr[0]  = if0.cpu_reset; assign cr[1]  = if1.cpu_reset;
  assign bsy[0] = if0.busy;      assign bsy[1] = if1.busy;
  assign ovr[0] = if0.overrun;   assign ovr[1] = if1.overrun;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  // Reference model state: what the bridge should remember per instance.
  bit          valid_m [2];
  logic [31:0] sh_acc  [2];
  logic [31:0] sh_clk  [2];

  function automatic int hdr_en(int d);  return (d == 0) ? 1 : 0;   endfunction
  function automatic int acc_w(int d);   return (d == 0) ? 16 : 24; endfunction
  function automatic int clk_w(int d);   return (d == 0) ? 8 : 12;  endfunction
  function automatic int qsize(int d);   return (d == 0) ? q0.size() : q1.size(); endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(int d, logic [7:0] b);
    if (d == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic push_result(int d);
    if (hdr_en(d) != 0) push(d, 8'hA5);
    for (int i = 0; i < (acc_w(d) + 7) / 8; i++) push(d, 8'(sh_acc[d] >> (8 * i)));
    for (int i = 0; i < (clk_w(d) + 7) / 8; i++) push(d, 8'(sh_clk[d] >> (8 * i)));
  endtask

  task automatic pop_check(int d, logic [7:0] act);
    logic [7:0] e;
    if (qsize(d) == 0) begin
      n_chk++;
      $display("FAIL unexpected_tx dut%0d: got %0h expected no byte", d, act);
    end else begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("tx_byte dut%0d", d), 32'(act), 32'(e));
    end
  endtask

  // Monitor: every tx_start is checked against the scoreboard.
  int cyc = 0;
  int n_txs [2];
  int n_cs  [2];
  int n_cr  [2];
  int t_cs  [2];
  bit armed [2];
  int run_len [2];
  initial begin
    for (int d = 0; d < 2; d++) begin
      n_txs[d] = 0; n_cs[d] = 0; n_cr[d] = 0; t_cs[d] = 0; armed[d] = 0; run_len[d] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (cs[d]) begin n_cs[d]++; t_cs[d] = cyc; armed[d] = 1'b1; end
        if (cr[d]) n_cr[d]++;
        if (txs[d]) begin
          n_txs[d]++;
          if (armed[d]) begin run_len[d] = cyc - t_cs[d]; armed[d] = 1'b0; end
          pop_check(d, txd[d]);
        end
      end
    end
  end

  // UART TX stand-in: completes each byte a few cycles after tx_start.
  int tdly [2];
  initial begin
    tx_tick[0] = 1'b0; tx_tick[1] = 1'b0; tdly[0] = 0; tdly[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (tx_tick[d]) tx_tick[d] = 1'b0;
        else if (txs[d]) tdly[d] = $urandom_range(2, 5);
        else if (tdly[d] > 0) begin
          tdly[d]--;
          if (tdly[d] == 0) tx_tick[d] = 1'b1;
        end
      end
    end
  end

  task automatic send(int d, logic [7:0] b);
    @(negedge clk);
    rx_byte[d] = b;
    rx_tick[d] = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rx_tick[d] = 1'b0;
  endtask

  task automatic wait_idle(int d);
    int n;
    n = 0;
    while (n < 3000 && !(qsize(d) == 0 && bsy[d] == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_reached dut%0d", d), 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // dly < 0 means the CPU never reports done.
  task automatic do_cmd(int d, logic [7:0] cmd, int dly);
    case (cmd)
      8'h01: begin
        if (dly >= 0) begin
          sh_acc[d]  = acc_v[d] & ((32'd1 << acc_w(d)) - 32'd1);
          sh_clk[d]  = clk_v[d] & ((32'd1 << clk_w(d)) - 32'd1);
          valid_m[d] = 1'b1;
          push_result(d);
        end else begin
          push(d, 8'hE1);
        end
      end
      8'h02: begin push(d, 8'hAC); valid_m[d] = 1'b0; end
      8'h03: begin if (valid_m[d]) push_result(d); else push(d, 8'hE2); end
      default: push(d, 8'hEE);
    endcase
    send(d, cmd);
    if (cmd == 8'h01 && dly >= 0) begin
      repeat (dly) @(negedge clk);
      done[d] = 1'b1;
    end
    wait_idle(d);
    done[d] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_cs, base_cr, base_tx, n, d, r, dly;
    logic [7:0] cmd;
    for (int i = 0; i < 2; i++) begin
      rx_tick[i] = 1'b0; rx_byte[i] = 8'h00; done[i] = 1'b0;
      acc_v[i] = 32'd0; clk_v[i] = 32'd0; valid_m[i] = 1'b0; sh_acc[i] = 32'd0; sh_clk[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outputs dut%0d", i), 32'({txs[i], txd[i], cs[i], cr[i], bsy[i], ovr[i]}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start, CPU done after 20 cycles, 4-byte framed result.
    acc_v[0] = 32'h1234; clk_v[0] = 32'h2A;
    base_cs = n_cs[0]; base_tx = n_txs[0];
    do_cmd(0, 8'h01, 20);
    chk("cpu_start_cycles", 32'(n_cs[0] - base_cs), 32'd1);
    chk("result_tx_count", 32'(n_txs[0] - base_tx), 32'd4);

    // Resend uses the shadow copy; then CPU reset ack and resend with no result.
    acc_v[0] = 32'hFFFF;
    do_cmd(0, 8'h03, 0);
    base_cr = n_cr[0];
    do_cmd(0, 8'h02, 0);
    chk("cpu_reset_cycles", 32'(n_cr[0] - base_cr), 32'd1);
    do_cmd(0, 8'h03, 0);

    // Stale done level must not end RUN in its first cycle.
    acc_v[0] = 32'h0BEE; clk_v[0] = 32'h77;
    done[0] = 1'b1;
    do_cmd(0, 8'h01, 0);
    chk("stale_done_run_cycles", 32'(run_len[0] - 1), 32'd2);

    // Timeout after exactly 50 RUN cycles, result kept valid.
    do_cmd(0, 8'h01, -1);
    chk("timeout_run_cycles", 32'(run_len[0] - 1), 32'd50);
    do_cmd(0, 8'h03, 0);

    // Unknown command, then a byte dropped while a reply is in flight.
    push(0, 8'hEE);
    base_tx = n_txs[0]; base_cs = n_cs[0];
    send(0, 8'h7F);
    n = 0;
    while (n < 200 && n_txs[0] == base_tx) begin @(negedge clk); n++; end
    chk("reply_started", 32'(n < 200), 32'd1);
    send(0, 8'h01);
    chk("overrun_set", 32'(ovr[0]), 32'd1);
    wait_idle(0);
    chk("dropped_no_start", 32'(n_cs[0] - base_cs), 32'd0);
    chk("dropped_no_tx", 32'(n_txs[0] - base_tx), 32'd1);
    chk("overrun_sticky", 32'(ovr[0]), 32'd1);
    push(0, 8'hEE);
    send(0, 8'h55);
    chk("overrun_cleared", 32'(ovr[0]), 32'd0);
    wait_idle(0);

    // Wide parameter set without header.
    acc_v[1] = 32'hABCDEF; clk_v[1] = 32'h5A3;
    do_cmd(1, 8'h01, 5);
    do_cmd(1, 8'h03, 0);

    // Randomized command mix on both instances.
    for (int k = 0; k < 24; k++) begin
      d = $urandom_range(0, 1);
      acc_v[d] = $urandom;
      clk_v[d] = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0)      cmd = 8'h01;
      else if (r == 1) cmd = 8'h02;
      else if (r == 2) cmd = 8'h03;
      else             cmd = 8'($urandom_range(4, 255));
      dly = $urandom_range(1, 40);
      if (d == 0 && $urandom_range(0, 3) == 0) dly = -1;
      do_cmd(d, cmd, dly);
    end

    // Asynchronous reset in the middle of a resend frame.
    acc_v[0] = 32'h5AA5; clk_v[0] = 32'h3C;
    do_cmd(0, 8'h01, 10);
    push_result(0);
    base_tx = n_txs[0];
    send(0, 8'h03);
    n = 0;
    while (n < 200 && n_txs[0] == base_tx) begin @(negedge clk); n++; end
    chk("frame_started", 32'(n < 200), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({txs[0], txd[0], cs[0], cr[0], bsy[0], ovr[0]}), 32'd0);
    q0.delete(); q1.delete();
    valid_m[0] = 1'b0; valid_m[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base_tx = n_txs[0];
    repeat (30) @(negedge clk);
    chk("no_tx_after_reset", 32'(n_txs[0] - base_tx), 32'd0);
    do_cmd(0, 8'h03, 0);
    do_cmd(1, 8'h03, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
